mem_stage: RTL

- Memory-access pipeline stage between execute and writeback. Sits directly upstream of memory_interface.
- Accepts load, store and pass-through ops from execute using a valid/ready handshake, and drives the memory_interface request port.
- Tracks the op while memory_interface's one-cycle registered response is outstanding, then formats load data (sign/zero extension) and maps the response code to exceptions.
- Holds its result when writeback stalls; throughput is one op per cycle.

---
 rtl/mem_stage_pkg.sv | 54 +++++
 rtl/mem_stage_load_extend.sv | 34 +++
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory-access stage.
//   - datapath widths (address, word, request count, response code)
//   - MEMOP_* op classes from execute
//   - RV32 load/store funct3 encodings
//   - MEM_COUNT_* request sizes and MEM_CODE_* response codes used by
//     memory_interface
//   - funct3_to_count(): funct3 -> request size
//   - stage_state_t: occupancy of the single result slot
package mem_stage_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;
  localparam int MEMOP_W     = 2;

  localparam logic [MEMOP_W-1:0] MEMOP_NONE  = 2'd0;
  localparam logic [MEMOP_W-1:0] MEMOP_LOAD  = 2'd1;
  localparam logic [MEMOP_W-1:0] MEMOP_STORE = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE       = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_FAULT      = 3'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RESP  = 2'd1,
    ST_HOLD  = 2'd2
  } stage_state_t;

  // Only funct3[1:0] carries the size; bit 2 is the unsigned flag for loads.
  function automatic logic [MEM_COUNT_W-1:0] funct3_to_count(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return MEM_COUNT_BYTE;
      2'b01:   return MEM_COUNT_HALF;
      2'b10:   return MEM_COUNT_WORD;
      default: return MEM_COUNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// mem_stage_load_extend: combinational load-data formatter.
//   funct3 : RV32 load funct3 (LB, LH, LW, LBU, LHU)
//   raw    : zero-extended read data from memory_interface
//   ext    : sign- or zero-extended writeback word
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] raw,
  output logic [WORD_W-1:0] ext
);

  logic signed [7:0]        byte_s;
  logic signed [15:0]       half_s;
  logic signed [WORD_W-1:0] byte_sx;
  logic signed [WORD_W-1:0] half_sx;

  assign byte_s  = raw[7:0];
  assign half_s  = raw[15:0];
  assign byte_sx = WORD_W'(byte_s);
  assign half_sx = WORD_W'(half_s);

  always_comb begin
    ext = raw;
    case (funct3)
      F3_B:    ext = byte_sx;
      F3_H:    ext = half_sx;
      F3_BU:   ext = {{(WORD_W-8){1'b0}}, raw[7:0]};
      F3_HU:   ext = {{(WORD_W-16){1'b0}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
//   Execute side : i_valid/o_ready handshake, i_op, i_funct3, i_addr,
//                  i_wr_data, i_alu_result, i_rd, i_rd_we, i_flush
//   Memory side  : o_req_* drive memory_interface combinationally in the
//                  accept cycle; i_res_rd_data/i_res_code arrive one cycle later
//   Writeback    : o_valid/i_ready handshake, o_rd, o_rd_we, o_wb_data,
//                  o_exc, o_exc_code
// One op is tracked at a time: it issues on accept, its result is formatted
// from the live response in RESP, and is latched into HOLD if writeback stalls
// because the memory response is gone the following cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [MEMOP_W-1:0]     i_op,
  input  logic [2:0]             i_funct3,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [WORD_W-1:0]      i_wr_data,
  input  logic [WORD_W-1:0]      i_alu_result,
  input  logic [REG_ADDR_W-1:0]  i_rd,
  input  logic                   i_rd_we,
  input  logic                   i_flush,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  output logic                   o_req_wr_en,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [REG_ADDR_W-1:0]  o_rd,
  output logic                   o_rd_we,
  output logic [WORD_W-1:0]      o_wb_data,
  output logic                   o_exc,
  output logic [MEM_CODE_W-1:0]  o_exc_code
);

  stage_state_t state;

  logic accept;
  logic issue;

  logic [MEMOP_W-1:0]    op_p1;
  logic [2:0]            funct3_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  rd_we_p1;
  logic [WORD_W-1:0]     alu_p1;

  logic                  rd_we_fmt;
  logic [WORD_W-1:0]     wb_fmt;
  logic                  exc_fmt;
  logic [MEM_CODE_W-1:0] code_fmt;
  logic [WORD_W-1:0]     load_ext;

  logic [REG_ADDR_W-1:0] rd_p2;
  logic                  rd_we_p2;
  logic [WORD_W-1:0]     wb_p2;
  logic                  exc_p2;
  logic [MEM_CODE_W-1:0] code_p2;

  // Stage 0: accept from execute and drive the memory request.
  // Gating with aresetn keeps the request port quiet while reset is held.
  assign o_ready = aresetn && ((state == ST_EMPTY) || (state == ST_RESP && i_ready));
  assign accept  = i_valid && o_ready && !i_flush;
  assign issue   = accept && (i_op == MEMOP_LOAD || i_op == MEMOP_STORE);

  assign o_req_addr    = issue ? i_addr : '0;
  assign o_req_wr_data = issue ? i_wr_data : '0;
  assign o_req_count   = issue ? funct3_to_count(i_funct3) : MEM_COUNT_NONE;
  assign o_req_wr_en   = issue && (i_op == MEMOP_STORE);

  // Stage 1: format the live response against the registered slot.
  mem_stage_load_extend u_load_extend (
    .funct3 (funct3_p1),
    .raw    (i_res_rd_data),
    .ext    (load_ext)
  );

  always_comb begin
    rd_we_fmt = 1'b0;
    wb_fmt    = '0;
    exc_fmt   = 1'b0;
    code_fmt  = MEM_CODE_NONE;
    case (op_p1)
      MEMOP_LOAD: begin
        if (i_res_code == MEM_CODE_READ) begin
          wb_fmt    = load_ext;
          rd_we_fmt = rd_we_p1;
        end else begin
          exc_fmt  = 1'b1;
          code_fmt = i_res_code;
        end
      end
      MEMOP_STORE: begin
        if (i_res_code != MEM_CODE_WRITE) begin
          exc_fmt  = 1'b1;
          code_fmt = i_res_code;
        end
      end
      default: begin
        wb_fmt    = alu_p1;
        rd_we_fmt = rd_we_p1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_EMPTY;
      op_p1     <= MEMOP_NONE;
      funct3_p1 <= '0;
      rd_p1     <= '0;
      rd_we_p1  <= 1'b0;
      alu_p1    <= '0;
      rd_p2     <= '0;
      rd_we_p2  <= 1'b0;
      wb_p2     <= '0;
      exc_p2    <= 1'b0;
      code_p2   <= MEM_CODE_NONE;
    end else begin
      if (accept) begin
        op_p1     <= i_op;
        funct3_p1 <= i_funct3;
        rd_p1     <= i_rd;
        rd_we_p1  <= i_rd_we;
        alu_p1    <= i_alu_result;
      end
      // Stage 2: capture the formatted result before the response disappears.
      if (state == ST_RESP && !i_ready) begin
        rd_p2    <= rd_p1;
        rd_we_p2 <= rd_we_fmt;
        wb_p2    <= wb_fmt;
        exc_p2   <= exc_fmt;
        code_p2  <= code_fmt;
      end
      if (i_flush) begin
        state <= ST_EMPTY;
      end else begin
        case (state)
          ST_EMPTY: if (accept) state <= ST_RESP;
          ST_RESP: begin
            if (!i_ready)     state <= ST_HOLD;
            else if (!accept) state <= ST_EMPTY;
          end
          ST_HOLD:  if (i_ready) state <= ST_EMPTY;
          default:  state <= ST_EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    o_valid    = 1'b0;
    o_rd       = '0;
    o_rd_we    = 1'b0;
    o_wb_data  = '0;
    o_exc      = 1'b0;
    o_exc_code = MEM_CODE_NONE;
    case (state)
      ST_RESP: begin
        o_valid    = !i_flush;
        o_rd       = rd_p1;
        o_rd_we    = rd_we_fmt;
        o_wb_data  = wb_fmt;
        o_exc      = exc_fmt;
        o_exc_code = code_fmt;
      end
      ST_HOLD: begin
        o_valid    = !i_flush;
        o_rd       = rd_p2;
        o_rd_we    = rd_we_p2;
        o_wb_data  = wb_p2;
        o_exc      = exc_p2;
        o_exc_code = code_p2;
      end
      default: ;
    endcase
  end

endmodule
